// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default widths, clock rate and a small index-wrap helper.
package uart_tx_arbiter_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int CLOCKS_PER_SECOND = 100_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    // Fold an index in [0, 2*n) back into [0, n); works for any n, not just powers of two.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      grant_idx_o,
    output logic               any_o
);

    logic [IW-1:0] idx;

    // Scan offsets 1..NUM_REQ from the last owner; the first set bit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'(wrap_idx(int'(last_i) + k, NUM_REQ));
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Each transfer:
// latch the winner's byte, pulse tx_enable/req_ready, wait for tx_done
// (or abort on timeout), then go back to IDLE.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = CLOCKS_PER_SECOND / 50,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_enable,
    input  logic                          tx_done,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    state_e                state_q;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         last_q;
    logic [IW-1:0]         grant_id_q;
    logic [DATA_WIDTH-1:0] tx_data_q, byte_d;
    logic [NUM_REQ-1:0]    req_ready_q;
    logic                  tx_enable_q;
    logic                  busy_q;

    logic [NUM_REQ-1:0]    win_onehot;
    logic [IW-1:0]         win_idx;
    logic                  any_req;
    logic                  timer_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i       (req_valid),
        .last_i      (last_q),
        .grant_o     (win_onehot),
        .grant_idx_o (win_idx),
        .any_o       (any_req)
    );

    // Winner's byte, saturating timer increment and timeout compare.
    always_comb begin
        byte_d    = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        timer_d   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        timer_hit = (timer_q == TIMER_LAST);
    end

    // Transfer sequencer; all handshake outputs are registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        tx_data_q   <= byte_d;
                        grant_id_q  <= win_idx;
                        last_q      <= win_idx;
                        req_ready_q <= win_onehot;
                        tx_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    req_ready_q <= '0;
                    tx_enable_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done || timer_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    req_ready_q <= '0;
                    tx_enable_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // timeout_err must see tx_done in the same cycle (done wins), so it is
    // decoded from registered state rather than registered itself.
    assign timeout_err = (state_q == WAIT_DONE) && timer_hit && !tx_done;

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule
